// File: rtl/adder_batch_checker.sv
// adder_batch_checker
//   Stimulus/response engine for a combinational adder under test. It drives
//   two operand buses, waits SETTLE_CYCLES, samples the adder's sum, compares
//   the sample with a golden sum and accumulates pass/fail statistics.
//
// Ports
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_start               start pulse, honoured in IDLE or DONE only
//   o_add_term1/2         registered operands to the adder
//   i_result              WIDTH+1 bit sum returned by the adder
//   o_busy / o_done       run in progress / run complete
//   o_pass                done with zero errors
//   o_err_count           saturating mismatch count
//   o_first_err_index     index of first mismatch, all-ones if none
//   o_vec_count           vectors checked in the current run
//
// state  | meaning
// IDLE   | waiting for the first start after reset
// DRIVE  | register operands and golden sum for the current index
// SETTLE | wait SETTLE_CYCLES for the adder to settle
// CHECK  | compare sampled result, update statistics, advance index
// DONE   | run complete, results held until the next start
module adder_batch_checker #(
  parameter int          WIDTH         = 14,
  parameter int          NUM_VECTORS   = 256,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] SEED1         = 16'hACE1,
  parameter logic [15:0] SEED2         = 16'h1D2C,
  parameter int          ERR_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_add_term1,
  output logic [WIDTH-1:0] o_add_term2,
  input  logic [WIDTH:0]   i_result,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic [15:0]      o_first_err_index,
  output logic [15:0]      o_vec_count
);

  localparam logic [15:0]      SEED1_EFF = (SEED1 == 16'h0) ? 16'h0001 : SEED1;
  localparam logic [15:0]      SEED2_EFF = (SEED2 == 16'h0) ? 16'h0001 : SEED2;
  localparam logic [15:0]      LFSR_MASK = 16'hB400;
  localparam int               CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0]      LAST_IDX  = 16'(NUM_VECTORS - 1);
  localparam logic [WIDTH-1:0] OPND_MAX  = '1;
  localparam logic [WIDTH-1:0] OPND_ONE  = WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [15:0]        idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        lfsr1_q, lfsr1_d;
  logic [15:0]        lfsr2_q, lfsr2_d;
  logic [WIDTH-1:0]   term1_q, term1_d;
  logic [WIDTH-1:0]   term2_q, term2_d;
  logic [WIDTH:0]     gold_q, gold_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [15:0]        first_q, first_d;
  logic [15:0]        vec_q, vec_d;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      lfsr1_q <= SEED1_EFF;
      lfsr2_q <= SEED2_EFF;
      term1_q <= '0;
      term2_q <= '0;
      gold_q  <= '0;
      err_q   <= '0;
      first_q <= '1;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lfsr1_q <= lfsr1_d;
      lfsr2_q <= lfsr2_d;
      term1_q <= term1_d;
      term2_q <= term2_d;
      gold_q  <= gold_d;
      err_q   <= err_d;
      first_q <= first_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lfsr1_d = lfsr1_q;
    lfsr2_d = lfsr2_q;
    term1_d = term1_q;
    term2_d = term2_q;
    gold_d  = gold_q;
    err_d   = err_q;
    first_d = first_q;
    vec_d   = vec_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          err_d   = '0;
          vec_d   = '0;
          first_d = '1;
          lfsr1_d = SEED1_EFF;
          lfsr2_d = SEED2_EFF;
        end
      end
      S_DRIVE: begin
        unique case (idx_q)
          16'd0: begin term1_d = '0;       term2_d = '0;       end
          16'd1: begin term1_d = OPND_MAX; term2_d = OPND_MAX; end
          16'd2: begin term1_d = OPND_MAX; term2_d = OPND_ONE; end
          16'd3: begin term1_d = '0;       term2_d = OPND_MAX; end
          default: begin
            // Pseudo-random vectors use the freshly advanced LFSR value.
            lfsr1_d = lfsr_step(lfsr1_q);
            lfsr2_d = lfsr_step(lfsr2_q);
            term1_d = lfsr1_d[WIDTH-1:0];
            term2_d = lfsr2_d[WIDTH-1:0];
          end
        endcase
        gold_d  = {1'b0, term1_d} + {1'b0, term2_d};
        cnt_d   = CNT_LOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CHECK: begin
        vec_d = vec_q + 16'd1;
        if (i_result != gold_q) begin
          if (err_q != '1)    err_d   = err_q + 1'b1;
          if (first_q == '1)  first_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_add_term1       = term1_q;
  assign o_add_term2       = term2_q;
  assign o_busy            = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign o_done            = (state_q == S_DONE);
  assign o_pass            = (state_q == S_DONE) && (err_q == '0);
  assign o_err_count       = err_q;
  assign o_first_err_index = first_q;
  assign o_vec_count       = vec_q;

endmodule
